scalar_writeback_queue: RTL

Buffers scalar results from the ALU and the load unit and drains them one per cycle into the scalar register file write port (WA3W / ResultW / RegWriteW). It sits at the end of the writeback stage, upstream of the register file. It filters writes the register file must not receive. It also gives the hazard/forwarding unit a lookup of writes that are still pending.

---
 rtl/scalar_writeback_queue_if.sv | 35 +++
 rtl/scalar_writeback_queue.sv | 89 ++++++++
 2 files changed

// File: rtl/scalar_writeback_queue_if.sv
// Handshake, drain and hazard-lookup signals of the scalar writeback queue.
// The producer/testbench side uses master; the queue itself uses slave.
interface scalar_writeback_queue_if #(
   parameter int N = 32
);
   // valid/ready: a result transfers on a rising edge where valid && ready are
   // both high; the producer holds valid, addr and data stable until then.
   logic         ld_valid;
   logic [4:0]   ld_addr;
   logic [N-1:0] ld_data;
   logic         ld_ready;
   logic         alu_valid;
   logic [4:0]   alu_addr;
   logic [N-1:0] alu_data;
   logic         alu_ready;
   logic         wb_stall;
   logic [4:0]   q_addr;
   logic         q_hit;
   logic [N-1:0] q_data;
   logic [4:0]   WA3W;
   logic [N-1:0] ResultW;
   logic         RegWriteW;

   modport slave (
      input  ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
      input  wb_stall, q_addr,
      output ld_ready, alu_ready, q_hit, q_data, WA3W, ResultW, RegWriteW
   );

   modport master (
      output ld_valid, ld_addr, ld_data, alu_valid, alu_addr, alu_data,
      output wb_stall, q_addr,
      input  ld_ready, alu_ready, q_hit, q_data, WA3W, ResultW, RegWriteW
   );
endinterface

// File: rtl/scalar_writeback_queue.sv
// Circular FIFO between the load unit / ALU and the scalar register-file write
// port; drops writes the register file must not see and offers a pending-write lookup.
module scalar_writeback_queue #(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   scalar_writeback_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [3:0]    addr_mem [DEPTH];
   logic [N-1:0]  data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic          ld_push;
   logic          alu_push;
   logic          pop;
   logic [PW-1:0] alu_slot;

   // Vector registers, the zero register and the pc never reach this file.
   function automatic logic keep_addr(input logic [4:0] a);
      return !a[4] && (a[3:0] != 4'd0) && (a[3:0] != 4'd15);
   endfunction

   // Readies look only at the registered count, so a full queue stalls
   // producers even in a cycle where it drains.
   assign bus.ld_ready  = !rst && (count < DEPTH_C);
   assign bus.alu_ready = !rst && ((count + CW'(bus.ld_valid)) < DEPTH_C);

   assign ld_push  = bus.ld_valid  && bus.ld_ready  && keep_addr(bus.ld_addr);
   assign alu_push = bus.alu_valid && bus.alu_ready && keep_addr(bus.alu_addr);
   assign pop      = (count != '0) && !bus.wb_stall;
   assign alu_slot = wr_ptr + PW'(ld_push);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         wr_ptr <= wr_ptr + PW'(ld_push) + PW'(alu_push);
         count  <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
      end
   end

   // The load is older than a same-cycle ALU result, so it takes the lower slot.
   always_ff @(posedge clk) begin
      if (ld_push) begin
         addr_mem[wr_ptr] <= bus.ld_addr[3:0];
         data_mem[wr_ptr] <= bus.ld_data;
      end
      if (alu_push) begin
         addr_mem[alu_slot] <= bus.alu_addr[3:0];
         data_mem[alu_slot] <= bus.alu_data;
      end
   end

   assign bus.RegWriteW = pop;
   assign bus.WA3W      = pop ? {1'b0, addr_mem[rd_ptr]} : 5'd0;
   assign bus.ResultW   = pop ? data_mem[rd_ptr] : '0;

   // Scan oldest to youngest so the last match seen is the youngest pending write.
   always_comb begin
      logic [PW-1:0] idx;
      logic          hit;
      logic [N-1:0]  hit_data;
      idx      = '0;
      hit      = 1'b0;
      hit_data = '0;
      if (keep_addr(bus.q_addr)) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == bus.q_addr[3:0])) begin
               hit      = 1'b1;
               hit_data = data_mem[idx];
            end
         end
      end
      bus.q_hit  = hit;
      bus.q_data = hit_data;
   end
endmodule
